alu_mdu_param: RTL and testbench
================================

// Module: alu_mdu_param
// PURPOSE
//   Next-generation processor ALU: width-parametrised, posedge-registered, with a
//   valid/ready request handshake, status flags and an iterative multiply/divide
//   unit (MDU). Sits in the execute stage between the register file and writeback/PC logic.
//   Single-cycle ops complete in 1 cycle. MUL/DIV stall the requester via o_ready.
// PARAMETERS
//   WIDTH  16  datapath width (>=8)
//   IMM_W   8  immediate width (<=WIDTH)
// PORTS
//   i_clk         in   1      clock, all state updates on rising edge
//   i_rst         in   1      synchronous reset, active-high
//   i_valid       in   1      operation request
//   o_ready       out  1      1 = idle, request accepted this edge
//   i_aluop       in   5      [4:1] opcode, [0] modifier (signed/high/select)
//   i_dataA       in   WIDTH  operand A
//   i_dataB       in   WIDTH  operand B
//   i_imm         in   IMM_W  immediate
//   o_valid       out  1      1-cycle pulse: o_dataResult/o_flags/o_shldBranch updated
//   o_dataResult  out  WIDTH  result, held until next o_valid
//   o_shldBranch  out  1      branch decision, held until next o_valid
//   o_flags       out  4      {C,V,N,Z}, held until next o_valid
// BEHAVIOUR
//   Reset: state IDLE, o_ready=1, o_valid=0, o_dataResult=0, o_shldBranch=0, o_flags=0.
//   Accept = i_valid & o_ready at rising edge; operands/op captured then.
//   i_valid while o_ready=0 ignored; requester holds request until accepted.
//   Single-cycle ops: o_valid next cycle; o_ready stays 1, back-to-back accepts allowed.
//   Opcodes (lsb = i_aluop[0]):
//     0 ADD  A+B; C = carry out; V = signed overflow
//     1 SUB  A-B; C = borrow; V = signed overflow
//     2 OR / 3 AND / 4 XOR  bitwise;  5 NOT  ~A
//     6 RDMEM / 7 WRMEM  address = A + sign-extended imm
//     8 LOAD lsb=1: imm in top IMM_W bits, rest 0; lsb=0: zero-extended imm
//     9 CMP  bits[4:0] = {A<B, A>B, B==0, A==0, A==B}; signed if lsb; upper bits 0
//    10 SHL  A << B[$clog2(WIDTH)-1:0]
//    11 SHR  logical if lsb=0, arithmetic if lsb=1
//    12 JMPA result = lsb ? A : zero-ext imm; branch=1
//    13 JMPR result = A; branch = B[{lsb,imm[1:0]}]
//    14 MUL  low WIDTH bits of A*B; signed if lsb; shift-add, 1 bit/cycle
//    15 DIV  unsigned restoring; lsb=0 quotient, lsb=1 remainder
//   Branch=0 for all ops except JMPA/JMPR.
//   Z = (result==0); N = result[WIDTH-1]. C,V = 0 except ADD/SUB and DIV-by-zero.
//   FSM: IDLE -> BUSY on MUL/DIV accept (o_ready=0); BUSY counts WIDTH iterations
//     -> IDLE with o_valid at end. MUL/DIV latency = WIDTH+1 cycles accept->o_valid.
//     o_ready returns to 1 in the o_valid cycle.
//   DIV by zero: no iteration; o_valid next cycle; quotient all-ones, remainder = A; V=1.
//   i_rst mid-operation: abort to IDLE, no o_valid, outputs cleared to reset values.
// TESTING
//   ADD lsb=1 A=16'h7FFF B=1 -> o_valid next cycle, result 16'h8000, flags V=1,N=1,C=0,Z=0.
//   MUL lsb=0 A=300 B=200 -> o_ready low 16 cycles, o_valid at +17, result 16'hEA60.
//   MUL lsb=1 A=-3 B=5 -> result 16'hFFF1, N=1. DIV A=100 B=7 -> 14; lsb=1 -> 2.
//   DIV A=5 B=0 -> o_valid next cycle, result 16'hFFFF, V=1. lsb=1 -> result 5.
//   MUL accepted, i_rst at cycle 5 -> no o_valid; o_ready=1, all outputs 0 next cycle.
//   JMPR A=16'h1234 B=16'h0010 lsb=1 imm=0 -> branch=1 (B[4]); ADD while BUSY ignored.

Source files
------------

// File: rtl/alu_mdu_param_if.sv
// Request/response bundle for alu_mdu_param.
//   i_valid/o_ready : request handshake (accept = i_valid & o_ready at posedge)
//   i_aluop         : [4:1] opcode, [0] modifier
//   i_dataA/B, i_imm: operands
//   o_valid         : 1-cycle pulse, result/flags/branch updated
//   o_dataResult, o_shldBranch, o_flags {C,V,N,Z}: held until next o_valid
interface alu_mdu_param_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [4:0]       i_aluop;
  logic [WIDTH-1:0] i_dataA;
  logic [WIDTH-1:0] i_dataB;
  logic [IMM_W-1:0] i_imm;
  logic             o_valid;
  logic [WIDTH-1:0] o_dataResult;
  logic             o_shldBranch;
  logic [3:0]       o_flags;

  modport master (
    output i_valid, i_aluop, i_dataA, i_dataB, i_imm,
    input  o_ready, o_valid, o_dataResult, o_shldBranch, o_flags
  );

  modport slave (
    input  i_valid, i_aluop, i_dataA, i_dataB, i_imm,
    output o_ready, o_valid, o_dataResult, o_shldBranch, o_flags
  );
endinterface

// File: rtl/alu_mdu_param.sv
// Execute-stage ALU with an iterative multiply/divide unit.
//   i_clk : clock, all state on rising edge
//   i_rst : synchronous active-high reset
//   bus   : alu_mdu_param_if slave (handshake, operands, result/flags/branch)
// Single-cycle ops register their result on accept. MUL/DIV run WIDTH
// iterations in BUSY with o_ready low; DIV by zero completes like a
// single-cycle op.
module alu_mdu_param #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input logic             i_clk,
  input logic             i_rst,
  alu_mdu_param_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_OR = 4'd2,    OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_RDM = 4'd6,   OP_WRM = 4'd7;
  localparam logic [3:0] OP_LD = 4'd8,   OP_CMP = 4'd9,  OP_SHL = 4'd10,  OP_SHR = 4'd11;
  localparam logic [3:0] OP_JMPA = 4'd12, OP_JMPR = 4'd13, OP_MUL = 4'd14, OP_DIV = 4'd15;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brn_q, brn_d;
  logic [3:0]       flg_q, flg_d;
  logic             vld_q, vld_d;
  // r: MUL accumulator / DIV partial remainder
  // x: MUL multiplicand (shifts left) / DIV dividend->quotient (shifts left)
  // y: MUL multiplier (shifts right) / DIV divisor
  logic [WIDTH-1:0] r_q, r_d, x_q, x_d, y_q, y_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d, mod_q, mod_d;

  wire [3:0]       opc = bus.i_aluop[4:1];
  wire             lsb = bus.i_aluop[0];
  wire [WIDTH-1:0] a   = bus.i_dataA;
  wire [WIDTH-1:0] b   = bus.i_dataB;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_brn, lt, gt;
  logic [SW-1:0]    jidx;

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};   // msb is the borrow
    lt      = lsb ? ($signed(a) < $signed(b)) : (a < b);
    gt      = lsb ? ($signed(a) > $signed(b)) : (a > b);
    jidx    = SW'({lsb, bus.i_imm[1:0]});
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_brn = 1'b0;
    case (opc)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_RDM, OP_WRM: alu_res = a + WIDTH'($signed(bus.i_imm));
      OP_LD:   alu_res = lsb ? (WIDTH'(bus.i_imm) << (WIDTH - IMM_W)) : WIDTH'(bus.i_imm);
      OP_CMP:  alu_res[4:0] = {lt, gt, b == '0, a == '0, a == b};
      OP_SHL:  alu_res = a << b[SW-1:0];
      OP_SHR:  alu_res = lsb ? $unsigned($signed(a) >>> b[SW-1:0]) : (a >> b[SW-1:0]);
      OP_JMPA: begin
        alu_res = lsb ? a : WIDTH'(bus.i_imm);
        alu_brn = 1'b1;
      end
      OP_JMPR: begin
        alu_res = a;
        alu_brn = b[jidx];
      end
      OP_DIV: begin
        // only reaches the output on divide-by-zero
        alu_res = lsb ? a : '1;
        alu_v   = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // ---------------- one MDU iteration ----------------
  logic [WIDTH:0]   dtmp, ddif;
  logic [WIDTH-1:0] it_r, it_x, fin;

  always_comb begin
    dtmp = {r_q, x_q[WIDTH-1]};
    ddif = dtmp - {1'b0, y_q};
    if (div_q) begin
      if (dtmp >= {1'b0, y_q}) begin
        it_r = ddif[WIDTH-1:0];
        it_x = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        it_r = dtmp[WIDTH-1:0];
        it_x = {x_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // low WIDTH bits of the product are sign-agnostic
      it_r = r_q + (y_q[0] ? x_q : '0);
      it_x = x_q << 1;
    end
    fin = (div_q && !mod_q) ? it_x : it_r;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    brn_d   = brn_q;
    flg_d   = flg_q;
    vld_d   = 1'b0;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mod_d   = mod_q;
    case (state_q)
      S_IDLE: if (bus.i_valid) begin
        if (opc == OP_MUL || (opc == OP_DIV && b != '0)) begin
          state_d = S_BUSY;
          r_d     = '0;
          x_d     = a;
          y_d     = b;
          cnt_d   = '0;
          div_d   = (opc == OP_DIV);
          mod_d   = lsb;
        end else begin
          res_d = alu_res;
          brn_d = alu_brn;
          flg_d = {alu_c, alu_v, alu_res[WIDTH-1], alu_res == '0};
          vld_d = 1'b1;
        end
      end
      S_BUSY: begin
        r_d   = it_r;
        x_d   = it_x;
        y_d   = div_q ? y_q : (y_q >> 1);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          res_d   = fin;
          brn_d   = 1'b0;
          flg_d   = {2'b00, fin[WIDTH-1], fin == '0};
          vld_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      brn_q   <= 1'b0;
      flg_q   <= '0;
      vld_q   <= 1'b0;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      brn_q   <= brn_d;
      flg_q   <= flg_d;
      vld_q   <= vld_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mod_q   <= mod_d;
    end
  end

  assign bus.o_ready      = (state_q == S_IDLE);
  assign bus.o_valid      = vld_q;
  assign bus.o_dataResult = res_q;
  assign bus.o_shldBranch = brn_q;
  assign bus.o_flags      = flg_q;
endmodule

// File: tb/tb_alu_mdu_param.sv
module tb_alu_mdu_param;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_mdu_param_if #(.WIDTH(16), .IMM_W(8)) bus ();
  alu_mdu_param #(.WIDTH(16), .IMM_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b;
    logic [7:0]  imm;
    logic [15:0] res;
    logic [3:0]  flg;
    logic        brn;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [7:0] imm, input logic [15:0] res, input logic [3:0] flg,
                              input logic brn);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.res = res; v.flg = flg; v.brn = brn;
    return v;
  endfunction

  // one-cycle request; returns #1 after the accepting edge
  task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] imm);
    bus.i_aluop = op; bus.i_dataA = a; bus.i_dataB = b; bus.i_imm = imm;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_aluop = '0; bus.i_dataA = '0; bus.i_dataB = '0; bus.i_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_dataResult !== 16'h0 ||
        bus.o_flags !== 4'h0 || bus.o_shldBranch !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b res=%h flg=%b brn=%b, expected 1 0 0000 0000 0",
               bus.o_ready, bus.o_valid, bus.o_dataResult, bus.o_flags, bus.o_shldBranch);
    end
    rst = 1'b0;
  endtask

  // flags are {C,V,N,Z}
  task automatic test_arith;
    vec_t t[$];
    t.push_back(mk({4'd0, 1'b1}, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 4'b0110, 1'b0));
    t.push_back(mk({4'd0, 1'b0}, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 4'b1001, 1'b0));
    t.push_back(mk({4'd1, 1'b0}, 16'h0005, 16'h0007, 8'h00, 16'hFFFE, 4'b1010, 1'b0));
    t.push_back(mk({4'd1, 1'b0}, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 4'b0100, 1'b0));
    t.push_back(mk({4'd1, 1'b1}, 16'h1234, 16'h1234, 8'h00, 16'h0000, 4'b0001, 1'b0));
    t.push_back(mk({4'd15, 1'b0}, 16'h0005, 16'h0000, 8'h00, 16'hFFFF, 4'b0110, 1'b0));
    t.push_back(mk({4'd15, 1'b1}, 16'h0005, 16'h0000, 8'h00, 16'h0005, 4'b0100, 1'b0));
    foreach (t[i]) begin
      drive(t[i].op, t[i].a, t[i].b, t[i].imm);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b1 || bus.o_dataResult !== t[i].res ||
          bus.o_flags !== t[i].flg || bus.o_shldBranch !== t[i].brn) begin
        errors++;
        $display("FAIL arith[%0d] op=%b: valid=%b ready=%b res=%h flg=%b brn=%b, expected 1 1 %h %b %b",
                 i, t[i].op, bus.o_valid, bus.o_ready, bus.o_dataResult, bus.o_flags,
                 bus.o_shldBranch, t[i].res, t[i].flg, t[i].brn);
      end
    end
  endtask

  task automatic test_logic;
    vec_t t[$];
    t.push_back(mk({4'd2, 1'b0}, 16'h00F0, 16'h0F00, 8'h00, 16'h0FF0, 4'b0000, 1'b0));
    t.push_back(mk({4'd3, 1'b0}, 16'hF0F0, 16'hFF00, 8'h00, 16'hF000, 4'b0010, 1'b0));
    t.push_back(mk({4'd4, 1'b0}, 16'hAAAA, 16'hAAAA, 8'h00, 16'h0000, 4'b0001, 1'b0));
    t.push_back(mk({4'd5, 1'b0}, 16'h00FF, 16'h1234, 8'h00, 16'hFF00, 4'b0010, 1'b0));
    t.push_back(mk({4'd6, 1'b0}, 16'h0100, 16'h0000, 8'hFE, 16'h00FE, 4'b0000, 1'b0));
    t.push_back(mk({4'd7, 1'b0}, 16'h0010, 16'h0000, 8'h05, 16'h0015, 4'b0000, 1'b0));
    t.push_back(mk({4'd8, 1'b1}, 16'h1111, 16'h2222, 8'hAB, 16'hAB00, 4'b0010, 1'b0));
    t.push_back(mk({4'd8, 1'b0}, 16'h1111, 16'h2222, 8'hAB, 16'h00AB, 4'b0000, 1'b0));
    t.push_back(mk({4'd10, 1'b0}, 16'h0001, 16'h0004, 8'h00, 16'h0010, 4'b0000, 1'b0));
    t.push_back(mk({4'd10, 1'b0}, 16'h0001, 16'h0013, 8'h00, 16'h0008, 4'b0000, 1'b0));
    t.push_back(mk({4'd11, 1'b0}, 16'h8000, 16'h0004, 8'h00, 16'h0800, 4'b0000, 1'b0));
    t.push_back(mk({4'd11, 1'b1}, 16'h8000, 16'h0004, 8'h00, 16'hF800, 4'b0010, 1'b0));
    foreach (t[i]) begin
      drive(t[i].op, t[i].a, t[i].b, t[i].imm);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_dataResult !== t[i].res ||
          bus.o_flags !== t[i].flg || bus.o_shldBranch !== t[i].brn) begin
        errors++;
        $display("FAIL logic[%0d] op=%b: valid=%b res=%h flg=%b brn=%b, expected 1 %h %b %b",
                 i, t[i].op, bus.o_valid, bus.o_dataResult, bus.o_flags, bus.o_shldBranch,
                 t[i].res, t[i].flg, t[i].brn);
      end
    end
  endtask

  task automatic test_cmp_branch;
    vec_t t[$];
    t.push_back(mk({4'd9, 1'b0}, 16'hFFFF, 16'h0001, 8'h00, 16'h0008, 4'b0000, 1'b0));
    t.push_back(mk({4'd9, 1'b1}, 16'hFFFF, 16'h0001, 8'h00, 16'h0010, 4'b0000, 1'b0));
    t.push_back(mk({4'd9, 1'b1}, 16'h0000, 16'h0000, 8'h00, 16'h0007, 4'b0000, 1'b0));
    t.push_back(mk({4'd12, 1'b0}, 16'h1234, 16'h0000, 8'h80, 16'h0080, 4'b0000, 1'b1));
    t.push_back(mk({4'd12, 1'b1}, 16'h1234, 16'h0000, 8'h80, 16'h1234, 4'b0000, 1'b1));
    t.push_back(mk({4'd13, 1'b1}, 16'h1234, 16'h0010, 8'h00, 16'h1234, 4'b0000, 1'b1));
    t.push_back(mk({4'd13, 1'b0}, 16'h1234, 16'h0010, 8'h02, 16'h1234, 4'b0000, 1'b0));
    foreach (t[i]) begin
      drive(t[i].op, t[i].a, t[i].b, t[i].imm);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_dataResult !== t[i].res ||
          bus.o_flags !== t[i].flg || bus.o_shldBranch !== t[i].brn) begin
        errors++;
        $display("FAIL cmp_branch[%0d] op=%b: valid=%b res=%h flg=%b brn=%b, expected 1 %h %b %b",
                 i, t[i].op, bus.o_valid, bus.o_dataResult, bus.o_flags, bus.o_shldBranch,
                 t[i].res, t[i].flg, t[i].brn);
      end
    end
  endtask

  task automatic test_back_to_back;
    bus.i_aluop = {4'd0, 1'b0}; bus.i_dataA = 16'd1; bus.i_dataB = 16'd2; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_dataResult !== 16'd3) begin
      errors++;
      $display("FAIL b2b_first: valid=%b res=%h, expected 1 0003", bus.o_valid, bus.o_dataResult);
    end
    bus.i_aluop = {4'd1, 1'b0}; bus.i_dataA = 16'd5; bus.i_dataB = 16'd1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_dataResult !== 16'd4) begin
      errors++;
      $display("FAIL b2b_second: valid=%b res=%h, expected 1 0004", bus.o_valid, bus.o_dataResult);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_dataResult !== 16'd4) begin
      errors++;
      $display("FAIL b2b_hold: valid=%b res=%h, expected 0 0004", bus.o_valid, bus.o_dataResult);
    end
  endtask

  task automatic test_mdu;
    vec_t t[$];
    int lat, low;
    t.push_back(mk({4'd14, 1'b0}, 16'd300, 16'd200, 8'h00, 16'hEA60, 4'b0010, 1'b0));
    t.push_back(mk({4'd14, 1'b1}, 16'hFFFD, 16'd5, 8'h00, 16'hFFF1, 4'b0010, 1'b0));
    t.push_back(mk({4'd15, 1'b0}, 16'd100, 16'd7, 8'h00, 16'd14, 4'b0000, 1'b0));
    t.push_back(mk({4'd15, 1'b1}, 16'd100, 16'd7, 8'h00, 16'd2, 4'b0000, 1'b0));
    t.push_back(mk({4'd15, 1'b0}, 16'hFFFF, 16'h0003, 8'h00, 16'h5555, 4'b0000, 1'b0));
    foreach (t[i]) begin
      drive(t[i].op, t[i].a, t[i].b, t[i].imm);
      lat = 1;
      low = (bus.o_ready === 1'b0) ? 1 : 0;
      while (bus.o_valid !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (bus.o_ready === 1'b0) low++;
      end
      checks++;
      if (lat != 17 || low != 16 || bus.o_ready !== 1'b1 || bus.o_dataResult !== t[i].res ||
          bus.o_flags !== t[i].flg || bus.o_shldBranch !== 1'b0) begin
        errors++;
        $display("FAIL mdu[%0d] op=%b: latency=%0d ready_low=%0d ready=%b res=%h flg=%b, expected 17 16 1 %h %b",
                 i, t[i].op, lat, low, bus.o_ready, bus.o_dataResult, bus.o_flags, t[i].res, t[i].flg);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    drive({4'd14, 1'b0}, 16'd300, 16'd200, 8'h00);
    // requester holds an ADD the whole time the MUL is running
    bus.i_aluop = {4'd0, 1'b0}; bus.i_dataA = 16'd1; bus.i_dataB = 16'd1; bus.i_valid = 1'b1;
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 17 || bus.o_dataResult !== 16'hEA60) begin
      errors++;
      $display("FAIL busy_mul: latency=%0d res=%h, expected 17 ea60", lat, bus.o_dataResult);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_dataResult !== 16'h0002 || bus.o_flags !== 4'b0000) begin
      errors++;
      $display("FAIL busy_held_add: valid=%b res=%h flg=%b, expected 1 0002 0000",
               bus.o_valid, bus.o_dataResult, bus.o_flags);
    end
  endtask

  task automatic test_rst_mid;
    int seen;
    drive({4'd13, 1'b1}, 16'h8001, 16'h0010, 8'h00);  // leaves res/N/branch nonzero
    drive({4'd14, 1'b0}, 16'd300, 16'd200, 8'h00);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_dataResult !== 16'h0 ||
        bus.o_flags !== 4'h0 || bus.o_shldBranch !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: ready=%b valid=%b res=%h flg=%b brn=%b, expected 1 0 0000 0000 0",
               bus.o_ready, bus.o_valid, bus.o_dataResult, bus.o_flags, bus.o_shldBranch);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.o_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_no_valid: o_valid pulses=%0d, expected 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_cmp_branch;
    test_back_to_back;
    test_mdu;
    test_busy_ignore;
    test_rst_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
